// File: rtl/gate_tester_if.sv
// Bundle of handshake, stimulus and result signals between the gate tester and its environment.
// The master side is the tester itself; the slave side is the stimulus/gate harness.
interface gate_tester_if #(
    parameter int N_IN  = 2,
    parameter int ERR_W = N_IN + 1
);
    logic             start;
    logic             dut_out;
    logic [N_IN-1:0]  dut_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [N_IN-1:0]  first_fail;
    logic             expected;

    modport master (
        input  start, dut_out,
        output dut_in, busy, done, pass, err_count, first_fail, expected
    );

    modport slave (
        output start, dut_out,
        input  dut_in, busy, done, pass, err_count, first_fail, expected
    );
endinterface

// File: rtl/gate_tester_auto.sv
// Clocked exhaustive gate tester: sweeps all 2**N_IN input vectors, holds each for
// SETTLE_CYC cycles, then checks the gate output against the selected logic function.
module gate_tester_auto #(
    parameter int N_IN       = 2,
    parameter int SETTLE_CYC = 4,
    parameter int GATE_MODE  = 0,
    parameter int ERR_W      = N_IN + 1
) (
    input logic          clk,
    input logic          reset_L,
    gate_tester_if.master bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] CHECK  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [N_IN-1:0]  VEC_LAST = '1;
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_IN-1:0]  dut_in_q, dut_in_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [N_IN-1:0]  first_fail_q, first_fail_d;
    logic             fail_seen_q, fail_seen_d;
    logic             expected_c;
    logic             mismatch_c;

    // Unknown modes fall back to NAND, the function of the original tester.
    always_comb begin
        expected_c = ~(&dut_in_q);
        case (GATE_MODE)
            1:       expected_c = ~(|dut_in_q);
            2:       expected_c = &dut_in_q;
            3:       expected_c = |dut_in_q;
            4:       expected_c = ^dut_in_q;
            5:       expected_c = ~dut_in_q[0];
            default: expected_c = ~(&dut_in_q);
        endcase
    end

    // Case inequality makes an X/Z gate output count as a failure.
    assign mismatch_c = (bus.dut_out !== expected_c);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dut_in_d     = dut_in_q;
        err_d        = err_q;
        first_fail_d = first_fail_q;
        fail_seen_d  = fail_seen_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d      = SETTLE;
                    cnt_d        = '0;
                    dut_in_d     = '0;
                    err_d        = '0;
                    first_fail_d = '0;
                    fail_seen_d  = 1'b0;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CHECK: begin
                if (mismatch_c) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    if (!fail_seen_q) begin
                        fail_seen_d  = 1'b1;
                        first_fail_d = dut_in_q;
                    end
                end
                if (dut_in_q == VEC_LAST) begin
                    state_d = DONE;
                end else begin
                    state_d  = SETTLE;
                    dut_in_d = dut_in_q + N_IN'(1);
                    cnt_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            dut_in_q     <= '0;
            err_q        <= '0;
            first_fail_q <= '0;
            fail_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dut_in_q     <= dut_in_d;
            err_q        <= err_d;
            first_fail_q <= first_fail_d;
            fail_seen_q  <= fail_seen_d;
        end
    end

    assign bus.dut_in     = dut_in_q;
    assign bus.busy       = (state_q == SETTLE) || (state_q == CHECK);
    assign bus.done       = (state_q == DONE);
    assign bus.pass       = (state_q == DONE) && (err_q == '0);
    assign bus.err_count  = err_q;
    assign bus.first_fail = first_fail_q;
    assign bus.expected   = expected_c;
endmodule
